pipeline_control: RTL and testbench



---
 rtl/pipeline_control.sv | 140 ++++++++++++++
 tb/tb_pipeline_control.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// pipeline_control
// Sequencing controller for the IF/ID, ID/EX, EX/MEM and MEM/WB bars of the
// five-stage pipeline. It decides each cycle which bars advance, which load a
// bubble and whether the PC updates. It also keeps saturating performance
// counters for stalls and squashes.
//
// Ports
//   CLK, nRST                 clock, asynchronous active-low reset
//   ihit, dhit                instruction / data memory completion this cycle
//   dREN_mem, dWEN_mem        instruction in MEM reads / writes data memory
//   dREN_ex, rt_ex            load in EX and its destination register
//   rs_id, rt_id              source registers of the instruction in IF/ID
//   branch_taken_mem          taken branch resolved in MEM
//   jump_ex                   j / jal / jr in EX
//   halt_wb                   halt flag at the MEM/WB output
//   pc_en                     PC loads its next value
//   en_1..en_4                bar n captures its inputs
//   flush_1..flush_3          bar n captures a bubble (only when enabled)
//   dmem_busy                 pipeline held waiting on data memory
//   halted                    sticky, registered halt indication
//   stall_cnt, flush_cnt      saturating 16-bit performance counters
module pipeline_control (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_mem,
  input  logic        dWEN_mem,
  input  logic        dREN_ex,
  input  logic [4:0]  rt_ex,  // regbits_t
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        branch_taken_mem,
  input  logic        jump_ex,
  input  logic        halt_wb,
  output logic        pc_en,
  output logic        en_1,
  output logic        en_2,
  output logic        en_3,
  output logic        en_4,
  output logic        flush_1,
  output logic        flush_2,
  output logic        flush_3,
  output logic        dmem_busy,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StDwait, StHalt} state_t;

  state_t      state_q, state_d;
  logic        halted_q;
  logic [15:0] stall_q, flush_q;
  logic        stall_inc, flush_inc;
  logic        mem_req, load_use;
  logic [4:1]  en;
  logic [3:1]  flush;

  assign mem_req  = dREN_mem | dWEN_mem;
  assign load_use = dREN_ex & (rt_ex != 5'd0) & ((rt_ex == rs_id) | (rt_ex == rt_id));

  always_comb begin
    pc_en     = 1'b0;
    en        = 4'b0000;
    flush     = 3'b000;
    dmem_busy = 1'b0;
    state_d   = state_q;
    flush_inc = 1'b0;
    unique case (state_q)
      StRun, StDwait: begin
        if (halt_wb) begin
          state_d = StHalt;
        end else if (mem_req && !dhit) begin
          // Busy covers every held cycle, including the one entering DWAIT.
          state_d   = StDwait;
          dmem_busy = 1'b1;
        end else begin
          state_d = StRun;
          if (branch_taken_mem) begin
            pc_en     = 1'b1;
            en        = 4'b1111;
            flush     = 3'b111;
            flush_inc = 1'b1;
          end else if (jump_ex) begin
            pc_en     = 1'b1;
            en        = 4'b1111;
            flush     = 3'b011;
            flush_inc = 1'b1;
          end else if (load_use) begin
            // IF/ID holds, bubble into EX.
            en    = 4'b1110;
            flush = 3'b010;
          end else if (!ihit) begin
            en    = 4'b1111;
            flush = 3'b001;
          end else begin
            pc_en = 1'b1;
            en    = 4'b1111;
          end
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StRun;
    endcase
    stall_inc = (state_q != StHalt) && !pc_en;
    if (!nRST) begin
      pc_en     = 1'b0;
      en        = 4'b0000;
      flush     = 3'b000;
      dmem_busy = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
      stall_q  <= 16'd0;
      flush_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_d == StHalt) halted_q <= 1'b1;
      if (stall_inc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush_inc && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign en_1      = en[1];
  assign en_2      = en[2];
  assign en_3      = en[3];
  assign en_4      = en[4];
  assign flush_1   = flush[1];
  assign flush_2   = flush[2];
  assign flush_3   = flush[3];
  assign halted    = halted_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, dREN_mem, dWEN_mem, dREN_ex;
  logic [4:0]  rt_ex, rs_id, rt_id;
  logic        branch_taken_mem, jump_ex, halt_wb;
  logic        pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, dmem_busy, halted;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_control dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_mem(dREN_mem),
    .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .branch_taken_mem(branch_taken_mem), .jump_ex(jump_ex), .halt_wb(halt_wb),
    .pc_en(pc_en), .en_1(en_1), .en_2(en_2), .en_3(en_3), .en_4(en_4),
    .flush_1(flush_1), .flush_2(flush_2), .flush_3(flush_3), .dmem_busy(dmem_busy),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ihit, dhit, drm, dwm, dre;
    logic [4:0] rt_ex, rs_id, rt_id;
    logic       br, jmp, hlt;
  } in_t;

  // ctl = {pc_en, en_1..en_4, flush_1..flush_3, dmem_busy}
  typedef struct packed {
    logic [8:0]  ctl;
    logic        halted;
    logic [15:0] scnt, fcnt;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t ex;
  } vec_t;

  localparam logic [8:0] ALL  = 9'b1_1111_000_0;
  localparam logic [8:0] FRZ  = 9'b0_0000_000_0;
  localparam logic [8:0] BUSY = 9'b0_0000_000_1;
  localparam logic [8:0] LU   = 9'b0_0111_010_0;
  localparam logic [8:0] IMS  = 9'b0_1111_100_0;
  localparam logic [8:0] BR   = 9'b1_1111_111_0;
  localparam logic [8:0] JMP  = 9'b1_1111_110_0;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl[20];

  function automatic in_t mk(logic ih, logic dh, logic drm, logic dwm, logic dre,
                             logic [4:0] rte, logic [4:0] rs, logic [4:0] rt,
                             logic br, logic j, logic h);
    in_t v;
    v = '{ihit: ih, dhit: dh, drm: drm, dwm: dwm, dre: dre, rt_ex: rte, rs_id: rs,
          rt_id: rt, br: br, jmp: j, hlt: h};
    return v;
  endfunction

  function automatic exp_t ex(logic [8:0] c, logic h, logic [15:0] s, logic [15:0] f);
    exp_t e;
    e = '{ctl: c, halted: h, scnt: s, fcnt: f};
    return e;
  endfunction

  task automatic drive(input in_t v);
    ihit = v.ihit; dhit = v.dhit; dREN_mem = v.drm; dWEN_mem = v.dwm; dREN_ex = v.dre;
    rt_ex = v.rt_ex; rs_id = v.rs_id; rt_id = v.rt_id;
    branch_taken_mem = v.br; jump_ex = v.jmp; halt_wb = v.hlt;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic check_now(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s: scoreboard empty, got 0 expected 1 entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".ctl"}, {7'd0, pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3,
                         dmem_busy}, {7'd0, e.ctl});
      chk({nm, ".halted"}, {15'd0, halted}, {15'd0, e.halted});
      chk({nm, ".stall_cnt"}, stall_cnt, e.scnt);
      chk({nm, ".flush_cnt"}, flush_cnt, e.fcnt);
    end
  endtask

  task automatic apply(input in_t v, input exp_t e, input string nm);
    @(posedge CLK);
    #1;
    drive(v);
    sb.push_back(e);
    @(negedge CLK);
    check_now(nm);
  endtask

  in_t idle;

  initial begin
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Sequence from reset; counters shown are those visible during the cycle.
    tbl[0]  = '{mk(1,0,0,0,0, 0,0,0, 0,0,0), ex(ALL,  0, 0, 0)};
    tbl[1]  = '{mk(1,0,0,0,1, 5,5,0, 0,0,0), ex(LU,   0, 0, 0)};
    tbl[2]  = '{mk(1,0,0,0,0, 5,5,0, 0,0,0), ex(ALL,  0, 1, 0)};
    tbl[3]  = '{mk(1,0,0,0,1, 0,0,0, 0,0,0), ex(ALL,  0, 1, 0)};
    tbl[4]  = '{mk(1,0,0,0,1, 7,3,7, 0,0,0), ex(LU,   0, 1, 0)};
    tbl[5]  = '{mk(1,0,1,0,0, 0,0,0, 0,0,0), ex(BUSY, 0, 2, 0)};
    tbl[6]  = '{mk(1,0,1,0,0, 0,0,0, 0,0,0), ex(BUSY, 0, 3, 0)};
    tbl[7]  = '{mk(1,0,1,0,0, 0,0,0, 0,0,0), ex(BUSY, 0, 4, 0)};
    tbl[8]  = '{mk(1,1,1,0,0, 0,0,0, 0,0,0), ex(ALL,  0, 5, 0)};
    tbl[9]  = '{mk(0,0,1,0,0, 0,0,0, 0,0,0), ex(BUSY, 0, 5, 0)};
    tbl[10] = '{mk(0,1,1,0,0, 0,0,0, 0,0,0), ex(IMS,  0, 6, 0)};
    tbl[11] = '{mk(1,0,0,0,1, 5,5,0, 1,1,0), ex(BR,   0, 7, 0)};
    tbl[12] = '{mk(1,0,0,0,0, 0,0,0, 0,1,0), ex(JMP,  0, 7, 1)};
    tbl[13] = '{mk(1,0,1,0,0, 0,0,0, 1,0,0), ex(BUSY, 0, 7, 2)};
    tbl[14] = '{mk(1,1,1,0,0, 0,0,0, 1,0,0), ex(BR,   0, 8, 2)};
    tbl[15] = '{mk(1,0,0,1,0, 0,0,0, 0,0,0), ex(BUSY, 0, 8, 3)};
    tbl[16] = '{mk(1,0,0,1,0, 0,0,0, 0,0,1), ex(FRZ,  0, 9, 3)};
    tbl[17] = '{mk(0,0,0,0,0, 0,0,0, 1,0,0), ex(FRZ,  1, 10, 3)};
    tbl[18] = '{mk(1,0,0,0,1, 5,5,0, 0,1,0), ex(FRZ,  1, 10, 3)};
    tbl[19] = '{mk(1,0,0,0,0, 0,0,0, 1,0,0), ex(FRZ,  1, 10, 3)};

    // Reset with live inputs: everything forced low.
    nRST = 1'b0;
    drive(mk(1, 0, 1, 0, 1, 5, 5, 0, 1, 1, 0));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    sb.push_back(ex(FRZ, 0, 0, 0));
    check_now("reset");
    drive(idle);
    @(posedge CLK);
    #1 nRST = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].in, tbl[i].ex, $sformatf("vec%0d", i));
    end

    // Asynchronous reset out of HALT, asserted between edges.
    #2 nRST = 1'b0;
    drive(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    sb.push_back(ex(FRZ, 0, 0, 0));
    check_now("halt_reset");
    drive(idle);
    @(posedge CLK);
    #1 nRST = 1'b1;
    apply(idle, ex(ALL, 0, 0, 0), "after_reset");

    // Saturation: long ihit miss run.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(IMS, 0, 0, 0), "sat_start");
    repeat (70000) @(posedge CLK);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(IMS, 0, 16'hFFFF, 0), "sat_hold");
    apply(idle, ex(ALL, 0, 16'hFFFF, 0), "sat_nowrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
